rvx_stream_bus_initiator: RTL and testbench

Bus initiator that turns a byte command stream (typically from a UART receiver) into single read/write transactions on the RVX peripheral register interface, and returns status and read data as a byte stream. It sits between a debug/loader byte link and the peripheral bus, driving the same request/response signals that peripherals such as the GPIO block answer. One transaction is outstanding at a time.

---
 rtl/rvx_stream_bus_initiator_pkg.sv | 33 +++
 rtl/rvx_stream_bus_initiator.sv | 213 +++++++++++++++++++++
 tb/tb_rvx_stream_bus_initiator.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvx_stream_bus_initiator_pkg.sv
// Shared types and codes for the byte-stream to RVX register-bus initiator.
// Covers FSM state encoding, command/status codes and opcode validation.
package rvx_stream_bus_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_REQ    = 3'd3,
    ST_WAIT   = 3'd4,
    ST_STATUS = 3'd5,
    ST_RDATA  = 3'd6
  } sbi_state_e;

  localparam logic [3:0] SBI_CMD_READ  = 4'h1;
  localparam logic [3:0] SBI_CMD_WRITE = 4'h2;

  localparam logic [7:0] SBI_STATUS_OK         = 8'h00;
  localparam logic [7:0] SBI_STATUS_TIMEOUT    = 8'h01;
  localparam logic [7:0] SBI_STATUS_BAD_OPCODE = 8'h02;

  // A write with no byte enabled would be a silent no-op, so it is rejected.
  function automatic logic opcode_is_valid(input logic [7:0] opcode);
    logic ok;
    case (opcode[7:4])
      SBI_CMD_READ:  ok = 1'b1;
      SBI_CMD_WRITE: ok = (opcode[3:0] != 4'h0);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rvx_stream_bus_initiator.sv
// Turns opcode/address/data byte frames into single RVX bus transactions and
// streams back a status byte plus read data. One transaction in flight at a time.
module rvx_stream_bus_initiator
  import rvx_stream_bus_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] rw_address,
  input  logic [31:0] read_data,
  output logic        read_request,
  input  logic        read_response,
  output logic [31:0] write_data,
  output logic [3:0]  write_strobe,
  output logic        write_request,
  input  logic        write_response
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  sbi_state_e  state_r;
  sbi_state_e  state_next_s;
  logic [1:0]  byte_cnt_r;
  logic [15:0] timer_r;
  logic        is_write_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic [3:0]  strobe_r;
  logic [7:0]  tx_data_r;
  logic        rx_fire_s;
  logic        tx_fire_s;
  logic        resp_hit_s;
  logic        timeout_s;

  // Handshake qualifiers; only the response matching the active command counts.
  always_comb begin
    rx_fire_s = rx_valid & rx_ready;
    tx_fire_s = tx_valid & tx_ready;
    if (is_write_r) begin
      resp_hit_s = write_response;
    end else begin
      resp_hit_s = read_response;
    end
    timeout_s = (timer_r == TIMER_LAST);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_fire_s) begin
          if (opcode_is_valid(rx_data)) begin
            state_next_s = ST_ADDR;
          end else begin
            state_next_s = ST_STATUS;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (rx_fire_s && (byte_cnt_r == 2'd3)) begin
          if (is_write_r) begin
            state_next_s = ST_DATA;
          end else begin
            state_next_s = ST_REQ;
          end
        end else begin
          state_next_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (rx_fire_s && (byte_cnt_r == 2'd3)) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_REQ: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (resp_hit_s || timeout_s) begin
          state_next_s = ST_STATUS;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_STATUS: begin
        if (tx_fire_s) begin
          if (!is_write_r && (tx_data_r == SBI_STATUS_OK)) begin
            state_next_s = ST_RDATA;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_STATUS;
        end
      end
      ST_RDATA: begin
        if (tx_fire_s && (byte_cnt_r == 2'd3)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RDATA;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode; gating with reset_n keeps the bus quiet during reset.
  always_comb begin
    rx_ready      = 1'b0;
    tx_valid      = 1'b0;
    read_request  = 1'b0;
    write_request = 1'b0;
    case (state_r)
      ST_IDLE, ST_ADDR, ST_DATA: rx_ready = reset_n;
      ST_REQ: begin
        read_request  = reset_n & ~is_write_r;
        write_request = reset_n & is_write_r;
      end
      ST_STATUS, ST_RDATA: tx_valid = reset_n;
      default: rx_ready = 1'b0;
    endcase
  end

  // Frame capture, timeout counter and response byte sequencing.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      byte_cnt_r <= 2'd0;
      timer_r    <= 16'd0;
      is_write_r <= 1'b0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      rdata_r    <= 32'd0;
      strobe_r   <= 4'h0;
      tx_data_r  <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rx_fire_s) begin
            byte_cnt_r <= 2'd0;
            if (opcode_is_valid(rx_data)) begin
              is_write_r <= (rx_data[7:4] == SBI_CMD_WRITE);
              if (rx_data[7:4] == SBI_CMD_WRITE) begin
                strobe_r <= rx_data[3:0];
              end else begin
                strobe_r <= 4'h0;
              end
            end else begin
              tx_data_r <= SBI_STATUS_BAD_OPCODE;
            end
          end
        end
        ST_ADDR: begin
          if (rx_fire_s) begin
            addr_r     <= {rx_data, addr_r[31:8]};
            byte_cnt_r <= byte_cnt_r + 2'd1;
          end
        end
        ST_DATA: begin
          if (rx_fire_s) begin
            wdata_r    <= {rx_data, wdata_r[31:8]};
            byte_cnt_r <= byte_cnt_r + 2'd1;
          end
        end
        ST_REQ: timer_r <= 16'd0;
        ST_WAIT: begin
          timer_r <= timer_r + 16'd1;
          if (resp_hit_s) begin
            tx_data_r <= SBI_STATUS_OK;
            if (!is_write_r) begin
              rdata_r <= read_data;
            end
          end else if (timeout_s) begin
            tx_data_r <= SBI_STATUS_TIMEOUT;
          end
        end
        ST_STATUS, ST_RDATA: begin
          if (tx_fire_s) begin
            tx_data_r  <= rdata_r[7:0];
            rdata_r    <= {8'h00, rdata_r[31:8]};
            byte_cnt_r <= (state_r == ST_STATUS) ? 2'd0 : byte_cnt_r + 2'd1;
          end
        end
        default: byte_cnt_r <= 2'd0;
      endcase
    end
  end

  assign tx_data      = tx_data_r;
  assign rw_address   = addr_r;
  assign write_data   = wdata_r;
  assign write_strobe = strobe_r;

endmodule

// File: tb/tb_rvx_stream_bus_initiator.sv
// Scoreboard bench: expected tx bytes are queued when a frame is driven and
// popped as the initiator emits them; the bench itself acts as the responder.
module tb_rvx_stream_bus_initiator;

  localparam int TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] rw_address;
  logic [31:0] read_data = 32'd0;
  logic        read_request;
  logic        read_response = 1'b0;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_request;
  logic        write_response = 1'b0;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          rd_req_cnt = 0;
  int          wr_req_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] gpio_mem[0:15];

  rvx_stream_bus_initiator #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rw_address(rw_address), .read_data(read_data),
    .read_request(read_request), .read_response(read_response),
    .write_data(write_data), .write_strobe(write_strobe),
    .write_request(write_request), .write_response(write_response)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (read_request) rd_req_cnt <= rd_req_cnt + 1;
    if (write_request) wr_req_cnt <= wr_req_cnt + 1;
  end

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Scoreboard: every accepted tx byte must match the head of the queue.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check_value("tx_unexpected", 32'(tx_data), 32'h0000_0100);
        end else begin
          check_value("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check_value("rst_rx_ready", 32'(rx_ready), 32'd0);
    check_value("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_value("rst_tx_data", 32'(tx_data), 32'd0);
    check_value("rst_requests", 32'({read_request, write_request}), 32'd0);
    check_value("rst_rw_address", rw_address, 32'd0);
    check_value("rst_write_data", write_data, 32'd0);
    check_value("rst_write_strobe", 32'(write_strobe), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) check_value("rx_ready_timeout", 32'(rx_ready), 32'd1);
    acc_cyc = cyc;
    @(negedge clock);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_value("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input bit respond, input bit stall);
    logic [3:0]  cmd;
    logic [3:0]  strb;
    logic [31:0] rval;
    bit          wr;
    bit          bad;
    int          op_cyc;
    int          req_cyc;
    int          dummy;
    int          n;
    int          rd0;
    int          wr0;
    cmd  = op[7:4];
    strb = op[3:0];
    wr   = (cmd == 4'h2);
    bad  = !((cmd == 4'h1) || (wr && strb != 4'h0));
    rd0  = rd_req_cnt;
    wr0  = wr_req_cnt;
    if (bad) begin
      exp_q.push_back(8'h02);
      send_byte(op, op_cyc);
      rx_valid = 1'b0;
      wait_drain();
      check_value("bad_op_no_request", 32'(rd_req_cnt + wr_req_cnt), 32'(rd0 + wr0));
      return;
    end
    rval = gpio_mem[addr[5:2]];
    if (!respond) begin
      exp_q.push_back(8'h01);
    end else if (wr) begin
      exp_q.push_back(8'h00);
    end else begin
      exp_q.push_back(8'h00);
      for (int i = 0; i < 4; i++) exp_q.push_back(rval[8*i +: 8]);
    end
    if (stall) tx_ready = 1'b0;
    send_byte(op, op_cyc);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], dummy);
    if (wr) begin
      for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], dummy);
    end
    rx_valid = 1'b0;
    n = 0;
    while (!(read_request || write_request) && n < 20) begin
      @(negedge clock);
      n++;
    end
    req_cyc = cyc;
    check_value("req_latency", 32'(req_cyc - op_cyc), wr ? 32'd9 : 32'd5);
    check_value("req_type", 32'({write_request, read_request}), wr ? 32'd2 : 32'd1);
    check_value("rw_address", rw_address, addr);
    check_value("write_strobe", 32'(write_strobe), wr ? 32'(strb) : 32'd0);
    if (wr) begin
      check_value("write_data", write_data, data);
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) gpio_mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
      end
    end
    @(posedge clock);
    #1;
    check_value("req_one_cycle", 32'({read_request, write_request}), 32'd0);
    if (respond) begin
      if (wr) begin
        write_response = 1'b1;
      end else begin
        read_data     = rval;
        read_response = 1'b1;
      end
      @(posedge clock);
      #1;
      read_response  = 1'b0;
      write_response = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!tx_valid && n < TIMEOUT + 20);
    check_value("tx_latency", 32'(cyc - req_cyc), respond ? 32'd2 : 32'(TIMEOUT + 1));
    if (stall) begin
      @(posedge clock);
      #1 tx_ready = 1'b1;
      @(posedge clock);
      #1 tx_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        check_value("stall_tx_valid", 32'(tx_valid), 32'd1);
        check_value("stall_tx_data", 32'(tx_data), 32'(exp_q[0]));
        check_value("stall_rx_ready", 32'(rx_ready), 32'd0);
      end
      @(posedge clock);
      #1 tx_ready = 1'b1;
    end
    wait_drain();
  endtask

  initial begin
    int dummy;
    int rd0;
    for (int i = 0; i < 16; i++) gpio_mem[i] = 32'h1000_0000 + 32'(i * 32'h0101_0101);
    gpio_mem[1] = 32'h0000_00A5;
    repeat (3) @(negedge clock);
    check_reset_outputs();
    reset_n = 1'b1;
    @(negedge clock);
    check_value("idle_rx_ready", 32'(rx_ready), 32'd1);

    run_frame(8'h10, 32'h0000_0004, 32'd0, 1'b1, 1'b0);
    run_frame(8'h2F, 32'h0000_0008, 32'h1234_5678, 1'b1, 1'b0);
    run_frame(8'h10, 32'h0000_0008, 32'd0, 1'b1, 1'b0);
    run_frame(8'h30, 32'd0, 32'd0, 1'b1, 1'b0);
    run_frame(8'h20, 32'd0, 32'd0, 1'b1, 1'b0);
    run_frame(8'h10, 32'h0000_0004, 32'd0, 1'b1, 1'b0);
    run_frame(8'h23, 32'h0000_0008, 32'hAABB_CCDD, 1'b1, 1'b0);
    run_frame(8'h10, 32'h0000_0008, 32'd0, 1'b1, 1'b0);

    // Silent responder, then late responses that must be ignored.
    run_frame(8'h10, 32'h0000_000C, 32'd0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    read_data      = 32'hDEAD_BEEF;
    read_response  = 1'b1;
    write_response = 1'b1;
    @(posedge clock);
    #1;
    read_response  = 1'b0;
    write_response = 1'b0;
    repeat (3) @(negedge clock);
    check_value("late_resp_no_tx", 32'(tx_valid), 32'd0);
    run_frame(8'h10, 32'h0000_0004, 32'd0, 1'b1, 1'b0);

    run_frame(8'h10, 32'h0000_0004, 32'd0, 1'b1, 1'b1);

    // Reset in the middle of the address bytes.
    rd0 = rd_req_cnt;
    send_byte(8'h10, dummy);
    send_byte(8'h34, dummy);
    send_byte(8'h12, dummy);
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    #1;
    check_value("rst_rx_ready_comb", 32'(rx_ready), 32'd0);
    repeat (2) @(negedge clock);
    check_reset_outputs();
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check_value("rst_no_request", 32'(rd_req_cnt), 32'(rd0));
    run_frame(8'h10, 32'h0000_0004, 32'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
